// File: rtl/rom_fetch_pkg.sv
// rtl/rom_fetch_pkg.sv - shared types and defaults for the ROM fetch sequencer
package rom_fetch_pkg;
  localparam logic [3:0] ADDR_HI_DEFAULT       = 4'h1;
  localparam int         ROM_ADDR_BITS_DEFAULT = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STOP,
    ST_START,
    ST_STREAM,
    ST_HOLD
  } state_e;
endpackage

// File: rtl/rom_fetch_stats.sv
// rtl/rom_fetch_stats.sv - saturating stream-restart counter
module rom_fetch_stats (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_i,
  output logic [15:0] count_o
);
  logic [15:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (inc_i && (count_q != 16'hFFFF)) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign count_o = count_q;
endmodule

// File: rtl/rom_fetch_sequencer.sv
// rtl/rom_fetch_sequencer.sv - one-byte cache in front of a streaming QSPI flash reader
// Optional restart statistics are enabled with ROM_FETCH_STATS_EN.
module rom_fetch_sequencer
  import rom_fetch_pkg::*;
#(
  parameter logic [3:0] ADDR_HI       = ADDR_HI_DEFAULT,
  parameter int         ROM_ADDR_BITS = ROM_ADDR_BITS_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               rom_bank,
  input  logic                     req_valid,
  input  logic [ROM_ADDR_BITS-1:0] req_addr,
  output logic                     rsp_ready,
  output logic [7:0]               rsp_data,
  output logic [23:0]              fl_addr,
  output logic                     fl_start,
  output logic                     fl_stall,
  output logic                     fl_stop,
  input  logic [7:0]               fl_data,
  input  logic                     fl_data_ready,
  input  logic                     fl_busy,
  output logic [15:0]              miss_count
);
  typedef logic [ROM_ADDR_BITS-1:0] addr_t;

  state_e state_q, state_d;
  addr_t  cur_addr_q, cur_addr_d;
  addr_t  nxt_addr_q, nxt_addr_d;
  addr_t  fl_lo_q, fl_lo_d;
  logic [7:0] cur_data_q, cur_data_d;
  logic   cur_valid_q, cur_valid_d;
  logic   stop_sent_q, stop_sent_d;
  logic   hit, miss;

  assign hit       = req_valid && cur_valid_q && (req_addr == cur_addr_q);
  assign miss      = req_valid && !hit;
  assign rsp_ready = hit;
  assign rsp_data  = cur_data_q;
  assign fl_addr   = {ADDR_HI, rom_bank, (fl_start ? req_addr : fl_lo_q)};

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    nxt_addr_d  = nxt_addr_q;
    fl_lo_d     = fl_lo_q;
    cur_data_d  = cur_data_q;
    cur_valid_d = cur_valid_q;
    stop_sent_d = stop_sent_q;
    fl_start    = 1'b0;
    fl_stop     = 1'b0;
    fl_stall    = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (miss) state_d = ST_START;
      end
      ST_START: begin
        fl_start    = 1'b1;
        fl_lo_d     = req_addr;
        nxt_addr_d  = req_addr;
        stop_sent_d = 1'b0;
        state_d     = ST_STREAM;
      end
      ST_STREAM: begin
        fl_stall = 1'b0;
        if (fl_data_ready) begin
          cur_data_d  = fl_data;
          cur_addr_d  = nxt_addr_q;
          cur_valid_d = 1'b1;
          nxt_addr_d  = nxt_addr_q + addr_t'(1);
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Next sequential byte just un-stalls the stream; anything else restarts it.
        if (miss) state_d = (req_addr == nxt_addr_q) ? ST_STREAM : ST_STOP;
      end
      ST_STOP: begin
        cur_valid_d = 1'b0;
        fl_stop     = !stop_sent_q;
        stop_sent_d = 1'b1;
        // Busy is only trusted from the cycle after the stop pulse.
        if (stop_sent_q && !fl_busy) state_d = ST_START;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cur_addr_q  <= '0;
      nxt_addr_q  <= '0;
      fl_lo_q     <= '0;
      cur_data_q  <= '0;
      cur_valid_q <= 1'b0;
      stop_sent_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      nxt_addr_q  <= nxt_addr_d;
      fl_lo_q     <= fl_lo_d;
      cur_data_q  <= cur_data_d;
      cur_valid_q <= cur_valid_d;
      stop_sent_q <= stop_sent_d;
    end
  end

`ifdef ROM_FETCH_STATS_EN
  rom_fetch_stats u_stats (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (fl_start),
    .count_o (miss_count)
  );
`else
  assign miss_count = '0;
`endif
endmodule

// File: tb/tb_rom_fetch_sequencer.sv
// tb/tb_rom_fetch_sequencer.sv - scoreboard bench for rom_fetch_sequencer with a behavioural flash model
module tb_rom_fetch_sequencer;
  import rom_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rom_bank = 8'h3C;
  logic        req_valid = 1'b0;
  logic [11:0] req_addr = '0;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic [23:0] fl_addr;
  logic        fl_start, fl_stall, fl_stop;
  logic [7:0]  fl_data;
  logic        fl_data_ready, fl_busy;
  logic [15:0] miss_count;

  int nchk = 0;
  int nfail = 0;
  logic [7:0] exp_q[$];

`ifdef ROM_FETCH_STATS_EN
  localparam logic [15:0] MC_AFTER_RUN = 16'd1;
`else
  localparam logic [15:0] MC_AFTER_RUN = 16'd0;
`endif

  always #5 clk = ~clk;

  rom_fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .rom_bank(rom_bank), .req_valid(req_valid), .req_addr(req_addr),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .fl_addr(fl_addr), .fl_start(fl_start),
    .fl_stall(fl_stall), .fl_stop(fl_stop), .fl_data(fl_data), .fl_data_ready(fl_data_ready),
    .fl_busy(fl_busy), .miss_count(miss_count)
  );

  function automatic logic [7:0] data_of(input logic [11:0] a);
    return 8'hA8 ^ a[7:0] ^ {4'h0, a[11:8]};
  endfunction

  // Flash model: 4-cycle first byte, 2-cycle next byte, busy clears 3 cycles after stop
  logic [11:0] fa;
  int cnt, stop_cnt;
  logic active;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fl_busy <= 1'b0; fl_data_ready <= 1'b0; fl_data <= '0;
      fa <= '0; cnt <= 0; stop_cnt <= 0; active <= 1'b0;
    end else begin
      fl_data_ready <= 1'b0;
      if (fl_stop) begin
        active <= 1'b0; stop_cnt <= 3;
      end else if (stop_cnt > 0) begin
        stop_cnt <= stop_cnt - 1;
        if (stop_cnt == 1) fl_busy <= 1'b0;
      end
      if (fl_start) begin
        active <= 1'b1; fl_busy <= 1'b1; fa <= fl_addr[11:0]; cnt <= 4;
      end else if (active && !fl_stall && !fl_data_ready) begin
        if (cnt > 1) cnt <= cnt - 1;
        else begin
          fl_data_ready <= 1'b1; fl_data <= data_of(fa); fa <= fa + 12'd1; cnt <= 2;
        end
      end
    end
  end

  int cyc = 0;
  int n_start = 0, n_stop = 0, n_release = 0, n_viol = 0, last_rdy_cyc = 0;
  logic [23:0] last_start_addr = '0;
  logic prev_stall = 1'b1;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rst_n) begin
      if (fl_start) begin n_start++; last_start_addr = fl_addr; end
      if (fl_stop) n_stop++;
      if ((fl_start && fl_stop) || (fl_start && fl_busy)) n_viol++;
      if (fl_data_ready) last_rdy_cyc = cyc;
      if (prev_stall && !fl_stall) n_release++;
      prev_stall = fl_stall;
    end else begin
      prev_stall = 1'b1;
    end
  end

  // Presents one request and waits (bounded) for rsp_ready; the expectation goes to the scoreboard.
  task automatic do_req(input logic [11:0] a, output logic ok, output logic [7:0] d,
                        output int lat, output int gap);
    exp_q.push_back(data_of(a));
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = a; lat = 0;
    #1;
    while (!rsp_ready && lat < 200) begin @(posedge clk); #2; lat++; end
    ok = rsp_ready; d = rsp_data; gap = cyc - last_rdy_cyc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0;
    repeat (2) @(posedge clk); #1;
    nchk++; if (rsp_ready !== 1'b0) begin nfail++; $display("FAIL reset_rsp_ready actual=%b required=0", rsp_ready); end
    nchk++; if (fl_start !== 1'b0 || fl_stop !== 1'b0) begin nfail++; $display("FAIL reset_fl_cmd actual start=%b stop=%b required 0/0", fl_start, fl_stop); end
    nchk++; if (fl_stall !== 1'b1) begin nfail++; $display("FAIL reset_fl_stall actual=%b required=1", fl_stall); end
    nchk++; if (fl_addr !== {4'h1, 8'h3C, 12'h000}) begin nfail++; $display("FAIL reset_fl_addr actual=%h required=%h", fl_addr, {4'h1, 8'h3C, 12'h000}); end
    nchk++; if (miss_count !== 16'd0) begin nfail++; $display("FAIL reset_miss_count actual=%0d required=0", miss_count); end
    nchk++; if (dut.state_q !== ST_IDLE || dut.cur_valid_q !== 1'b0) begin nfail++; $display("FAIL reset_state actual state=%0d valid=%b required IDLE/0", dut.state_q, dut.cur_valid_q); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_cold_read();
    logic ok; logic [7:0] d, e; int lat, gap, s;
    s = n_start;
    do_req(12'h100, ok, d, lat, gap);
    e = exp_q.pop_front();
    nchk++; if (ok !== 1'b1) begin nfail++; $display("FAIL cold_timeout actual rsp_ready=%b required=1", ok); end
    nchk++; if (d !== e) begin nfail++; $display("FAIL cold_data actual=%h required=%h", d, e); end
    nchk++; if (e !== 8'hA9) begin nfail++; $display("FAIL cold_model_data actual=%h required=a9", e); end
    nchk++; if (gap !== 1) begin nfail++; $display("FAIL cold_latency actual=%0d required=1 cycle after fl_data_ready", gap); end
    nchk++; if (n_start !== s + 1) begin nfail++; $display("FAIL cold_start_count actual=%0d required=%0d", n_start, s + 1); end
    nchk++; if (last_start_addr !== 24'h13C100) begin nfail++; $display("FAIL cold_fl_addr actual=%h required=13c100", last_start_addr); end
  endtask

  task automatic test_repeat();
    logic [7:0] e; int s, t, r;
    s = n_start; t = n_stop; r = n_release;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(data_of(12'h100));
      @(posedge clk); #2;
      e = exp_q.pop_front();
      nchk++; if (rsp_ready !== 1'b1 || rsp_data !== e) begin nfail++; $display("FAIL repeat_hit cycle %0d actual ready=%b data=%h required 1/%h", i, rsp_ready, rsp_data, e); end
    end
    nchk++; if (n_start !== s || n_stop !== t || n_release !== r) begin nfail++; $display("FAIL repeat_no_flash actual start/stop/release delta=%0d/%0d/%0d required 0/0/0", n_start - s, n_stop - t, n_release - r); end
  endtask

  task automatic test_sequential();
    logic ok; logic [7:0] d, e; int lat, gap, s, r;
    s = n_start; r = n_release;
    for (int a = 12'h101; a <= 12'h104; a++) begin
      do_req(12'(a), ok, d, lat, gap);
      e = exp_q.pop_front();
      nchk++; if (ok !== 1'b1 || d !== e) begin nfail++; $display("FAIL seq_data addr=%h actual ok=%b data=%h required 1/%h", a, ok, d, e); end
      nchk++; if (gap !== 1) begin nfail++; $display("FAIL seq_latency addr=%h actual=%0d required=1", a, gap); end
    end
    nchk++; if (n_start !== s) begin nfail++; $display("FAIL seq_single_start actual extra starts=%0d required=0", n_start - s); end
    nchk++; if (n_release !== r + 4) begin nfail++; $display("FAIL seq_stall_release actual=%0d required=4", n_release - r); end
    nchk++; if (miss_count !== MC_AFTER_RUN) begin nfail++; $display("FAIL seq_miss_count actual=%0d required=%0d", miss_count, MC_AFTER_RUN); end
  endtask

  task automatic test_jump();
    logic ok; logic [7:0] d, e; int lat, gap, s, t, v;
    s = n_start; t = n_stop; v = n_viol;
    do_req(12'h800, ok, d, lat, gap);
    e = exp_q.pop_front();
    nchk++; if (ok !== 1'b1 || d !== e) begin nfail++; $display("FAIL jump_data actual ok=%b data=%h required 1/%h", ok, d, e); end
    nchk++; if (n_stop !== t + 1) begin nfail++; $display("FAIL jump_stop_count actual=%0d required=1", n_stop - t); end
    nchk++; if (n_start !== s + 1 || last_start_addr[11:0] !== 12'h800) begin nfail++; $display("FAIL jump_restart actual starts=%0d addr=%h required 1/800", n_start - s, last_start_addr[11:0]); end
    nchk++; if (n_viol !== v) begin nfail++; $display("FAIL jump_cmd_rules actual violations=%0d required=0", n_viol - v); end
  endtask

  task automatic test_wrap();
    logic ok; logic [7:0] d, e; int lat, gap, s, t;
    do_req(12'hFFF, ok, d, lat, gap);
    e = exp_q.pop_front();
    nchk++; if (ok !== 1'b1 || d !== e) begin nfail++; $display("FAIL wrap_fff_data actual ok=%b data=%h required 1/%h", ok, d, e); end
    s = n_start; t = n_stop;
    do_req(12'h000, ok, d, lat, gap);
    e = exp_q.pop_front();
    nchk++; if (ok !== 1'b1 || d !== e) begin nfail++; $display("FAIL wrap_000_data actual ok=%b data=%h required 1/%h", ok, d, e); end
    nchk++; if (n_stop !== t || n_start !== s) begin nfail++; $display("FAIL wrap_no_restart actual stop/start delta=%0d/%0d required 0/0", n_stop - t, n_start - s); end
    nchk++; if (gap !== 1) begin nfail++; $display("FAIL wrap_streamed actual gap=%0d required=1", gap); end
  endtask

  task automatic test_drop_valid();
    logic ok; logic [7:0] d, e; int lat, gap, t;
    t = n_stop;
    @(posedge clk); #1; req_addr = 12'h001;
    @(posedge clk); #1; req_valid = 1'b0;
    repeat (10) @(posedge clk); #1;
    nchk++; if (dut.cur_valid_q !== 1'b1 || dut.cur_addr_q !== 12'h001 || n_stop !== t) begin nfail++; $display("FAIL drop_cached actual valid=%b addr=%h stops=%0d required 1/001/0", dut.cur_valid_q, dut.cur_addr_q, n_stop - t); end
    do_req(12'h001, ok, d, lat, gap);
    e = exp_q.pop_front();
    nchk++; if (ok !== 1'b1 || d !== e || lat !== 0) begin nfail++; $display("FAIL drop_hit actual ok=%b data=%h lat=%0d required 1/%h/0", ok, d, lat, e); end
  endtask

  task automatic test_reset_stream();
    logic ok; logic [7:0] d, e; int lat, gap, s, w;
    s = n_start; w = 0;
    @(posedge clk); #1; req_valid = 1'b1; req_addr = 12'h300;
    while (n_start == s && w < 100) begin @(posedge clk); #1; w++; end
    nchk++; if (dut.state_q !== ST_STREAM) begin nfail++; $display("FAIL rst_reach_stream actual state=%0d required STREAM", dut.state_q); end
    rst_n = 1'b0; req_valid = 1'b0;
    #1;
    nchk++; if (dut.state_q !== ST_IDLE || dut.cur_valid_q !== 1'b0 || fl_stall !== 1'b1) begin nfail++; $display("FAIL rst_mid_stream actual state=%0d valid=%b stall=%b required IDLE/0/1", dut.state_q, dut.cur_valid_q, fl_stall); end
    @(negedge clk); rst_n = 1'b1;
    s = n_start;
    do_req(12'h300, ok, d, lat, gap);
    e = exp_q.pop_front();
    nchk++; if (ok !== 1'b1 || d !== e) begin nfail++; $display("FAIL rst_refetch_data actual ok=%b data=%h required 1/%h", ok, d, e); end
    nchk++; if (n_start !== s + 1 || last_start_addr !== 24'h13C300) begin nfail++; $display("FAIL rst_fresh_start actual starts=%0d addr=%h required 1/13c300", n_start - s, last_start_addr); end
  endtask

  initial begin
    test_reset();
    test_cold_read();
    test_repeat();
    test_sequential();
    test_jump();
    test_wrap();
    test_drop_valid();
    test_reset_stream();
    nchk++; if (n_viol !== 0) begin nfail++; $display("FAIL cmd_rules actual violations=%0d required=0", n_viol); end
    nchk++; if (exp_q.size() !== 0) begin nfail++; $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
